// File: rtl/ram_read_arbiter_pkg.sv
// Shared types and default configuration for the SDRAM read-port arbiter.
package ram_read_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_BURST = 2'd2
    } arb_state_t;

    localparam logic CLIENT_0 = 1'b0;
    localparam logic CLIENT_1 = 1'b1;

    localparam int DEF_ADDR_WIDTH     = 23;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_BURST_WIDTH    = 9;
    localparam int DEF_TIMEOUT_CYCLES = 4096;
    localparam int DEF_MAX_WAIT       = 64;

endpackage

// File: rtl/ram_read_arbiter_burst_watchdog.sv
// Saturating idle counter for an in-flight burst; restarts on every returned word.
module ram_read_arbiter_burst_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic strobe,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count_r;

    // Idle-cycle counter: held at zero outside a burst and on each word strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CW{1'b0}};
        end else if (!enable || strobe) begin
            count_r <= {CW{1'b0}};
        end else if (count_r != {CW{1'b1}}) begin
            count_r <= count_r + CW'(1'b1);
        end
    end

    assign expired = enable && (count_r == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ram_read_arbiter.sv
// Arbitrates the single SDRAM read port between two burst readers; client 0 has priority.
// Define RAM_READ_ARBITER_FAIRNESS_EN to force a client-1 grant after MAX_WAIT waiting cycles.
module ram_read_arbiter
    import ram_read_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int BURST_WIDTH    = DEF_BURST_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_WAIT       = DEF_MAX_WAIT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   c0_rd_request,
    input  logic [ADDR_WIDTH-1:0]  c0_rd_address,
    input  logic [BURST_WIDTH-1:0] c0_rd_burst_length,
    output logic                   c0_rd_available,
    output logic [DATA_WIDTH-1:0]  c0_rd_data,
    output logic                   c0_rd_done,
    input  logic                   c1_rd_request,
    input  logic [ADDR_WIDTH-1:0]  c1_rd_address,
    input  logic [BURST_WIDTH-1:0] c1_rd_burst_length,
    output logic                   c1_rd_available,
    output logic [DATA_WIDTH-1:0]  c1_rd_data,
    output logic                   c1_rd_done,
    output logic                   rd_request,
    output logic [ADDR_WIDTH-1:0]  rd_address,
    output logic [BURST_WIDTH-1:0] rd_burst_length,
    input  logic                   rd_available,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   timeout_error,
    output logic                   owner
);

    localparam logic [BURST_WIDTH-1:0] LEN_ONE = BURST_WIDTH'(1'b1);

    // A zero-length request is still one word on the ram side
    function automatic logic [BURST_WIDTH-1:0] clamp_len(input logic [BURST_WIDTH-1:0] len);
        if (len == {BURST_WIDTH{1'b0}}) begin
            return LEN_ONE;
        end else begin
            return len;
        end
    endfunction

    arb_state_t             state_r, state_s;
    logic                   owner_r;
    logic [ADDR_WIDTH-1:0]  rd_address_r;
    logic [BURST_WIDTH-1:0] len_r;
    logic [BURST_WIDTH-1:0] word_cnt_r;
    logic                   rd_request_r;
    logic                   c0_done_r, c1_done_r;
    logic                   timeout_error_r;

    logic                   grant_s, grant_id_s;
    logic [ADDR_WIDTH-1:0]  grant_addr_s;
    logic [BURST_WIDTH-1:0] grant_len_s;
    logic                   rd_request_s, c0_done_s, c1_done_s, timeout_set_s;
    logic                   c0_fwd_s, c1_fwd_s;
    logic                   last_word_s, burst_end_s;
    logic                   wd_enable_s, wd_expired_s;
    logic                   fair_force_s;

    assign last_word_s = (word_cnt_r == (len_r - LEN_ONE));
    assign burst_end_s = (state_r == ARB_BURST) && rd_available && last_word_s;
    assign wd_enable_s = (state_r == ARB_BURST);

`ifdef RAM_READ_ARBITER_FAIRNESS_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_r;

    // Client-1 starvation counter: counts ungranted IDLE cycles, saturates at the limit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_r <= {WAIT_W{1'b0}};
        end else if (grant_s && (grant_id_s == CLIENT_1)) begin
            wait_r <= {WAIT_W{1'b0}};
        end else if ((state_r == ARB_IDLE) && c1_rd_request && (wait_r != WAIT_W'(MAX_WAIT))) begin
            wait_r <= wait_r + WAIT_W'(1'b1);
        end
    end

    assign fair_force_s = (wait_r == WAIT_W'(MAX_WAIT));
`else
    logic unused_cfg_s;
    assign unused_cfg_s = MAX_WAIT[0];
    assign fair_force_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and arbitration; the done cycle is kept idle so the finishing client can drop its request
    always_comb begin
        state_s    = state_r;
        grant_s    = 1'b0;
        grant_id_s = CLIENT_0;
        case (state_r)
            ARB_IDLE: begin
                if (!c0_done_r && !c1_done_r && (c0_rd_request || c1_rd_request)) begin
                    grant_s = 1'b1;
                    state_s = ARB_ISSUE;
                    if (c1_rd_request && (!c0_rd_request || fair_force_s)) begin
                        grant_id_s = CLIENT_1;
                    end else begin
                        grant_id_s = CLIENT_0;
                    end
                end else begin
                    state_s = ARB_IDLE;
                end
            end
            ARB_ISSUE: state_s = ARB_ISSUE == state_r ? ARB_BURST : ARB_IDLE;
            ARB_BURST: begin
                if (burst_end_s || wd_expired_s) begin
                    state_s = ARB_IDLE;
                end else begin
                    state_s = ARB_BURST;
                end
            end
            default: state_s = ARB_IDLE;
        endcase
    end

    // Output decode: next values of registered outputs and zero-latency word steering
    always_comb begin
        rd_request_s  = grant_s;
        c0_done_s     = 1'b0;
        c1_done_s     = 1'b0;
        timeout_set_s = 1'b0;
        c0_fwd_s      = 1'b0;
        c1_fwd_s      = 1'b0;
        if (grant_id_s == CLIENT_1) begin
            grant_addr_s = c1_rd_address;
            grant_len_s  = clamp_len(c1_rd_burst_length);
        end else begin
            grant_addr_s = c0_rd_address;
            grant_len_s  = clamp_len(c0_rd_burst_length);
        end
        if (state_r == ARB_BURST) begin
            c0_fwd_s      = rd_available && (owner_r == CLIENT_0) && c0_rd_request;
            c1_fwd_s      = rd_available && (owner_r == CLIENT_1) && c1_rd_request;
            c0_done_s     = burst_end_s && (owner_r == CLIENT_0);
            c1_done_s     = burst_end_s && (owner_r == CLIENT_1);
            timeout_set_s = wd_expired_s && !burst_end_s;
        end else begin
            c0_fwd_s      = 1'b0;
            c1_fwd_s      = 1'b0;
        end
    end

    // Grant latch, word counter, strobes and sticky error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_r         <= CLIENT_0;
            rd_address_r    <= {ADDR_WIDTH{1'b0}};
            len_r           <= {BURST_WIDTH{1'b0}};
            word_cnt_r      <= {BURST_WIDTH{1'b0}};
            rd_request_r    <= 1'b0;
            c0_done_r       <= 1'b0;
            c1_done_r       <= 1'b0;
            timeout_error_r <= 1'b0;
        end else begin
            if (grant_s) begin
                owner_r      <= grant_id_s;
                rd_address_r <= grant_addr_s;
                len_r        <= grant_len_s;
            end
            if (state_s != ARB_BURST) begin
                word_cnt_r <= {BURST_WIDTH{1'b0}};
            end else if ((state_r == ARB_BURST) && rd_available) begin
                word_cnt_r <= word_cnt_r + LEN_ONE;
            end
            rd_request_r    <= rd_request_s;
            c0_done_r       <= c0_done_s;
            c1_done_r       <= c1_done_s;
            timeout_error_r <= timeout_error_r | timeout_set_s;
        end
    end

    ram_read_arbiter_burst_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (wd_enable_s),
        .strobe (rd_available),
        .expired(wd_expired_s)
    );

    assign c0_rd_available = c0_fwd_s;
    assign c1_rd_available = c1_fwd_s;
    assign c0_rd_data      = c0_fwd_s ? rd_data : {DATA_WIDTH{1'b0}};
    assign c1_rd_data      = c1_fwd_s ? rd_data : {DATA_WIDTH{1'b0}};
    assign c0_rd_done      = c0_done_r;
    assign c1_rd_done      = c1_done_r;
    assign rd_request      = rd_request_r;
    assign rd_address      = rd_address_r;
    assign rd_burst_length = len_r;
    assign timeout_error   = timeout_error_r;
    assign owner           = owner_r;

endmodule

// File: doc/ram_read_arbiter.md
Name: ram_read_arbiter

Overview:
Shares the single SDRAM read port of the ram block between two burst readers: client 0 (video_controller, real-time, fixed priority) and client 1 (secondary reader, e.g. a scroll/copy engine).
- Sits between the readers and ram.
- Issues one burst at a time and counts returned words.
- Steers rd_data/rd_available to the owning client only.
- Flags a stalled burst via a watchdog.

Parameters:
ADDR_WIDTH, 23, word address width
DATA_WIDTH, 32, read word width
BURST_WIDTH, 9, burst length field width
TIMEOUT_CYCLES, 4096, cycles without a word before the burst is aborted
MAX_WAIT, 64, client-1 wait limit (fairness feature only)

Ports:
clk  in  1  system clock (108 MHz)
reset_n  in  1  asynchronous active-low reset
c0_rd_request  in  1  client 0 burst request (level)
c0_rd_address  in  ADDR_WIDTH  client 0 start address
c0_rd_burst_length  in  BURST_WIDTH  client 0 word count
c0_rd_available  out  1  word valid strobe to client 0
c0_rd_data  out  DATA_WIDTH  word to client 0
c0_rd_done  out  1  one-cycle pulse after last word of a client 0 burst
c1_*  (same six signals for client 1)
rd_request  out  1  to ram, one-cycle pulse per granted burst
rd_address  out  ADDR_WIDTH  to ram
rd_burst_length  out  BURST_WIDTH  to ram
rd_available  in  1  word strobe from ram
rd_data  in  DATA_WIDTH  word from ram
timeout_error  out  1  sticky watchdog flag
owner  out  1  current/last grant (0 or 1)

Behaviour:
- Reset (reset_n low, async): state IDLE; all *_rd_request/available/done outputs 0; rd_address, rd_burst_length, c*_rd_data 0; timeout_error 0; owner 0; counters 0. Reset mid-burst abandons the burst; words arriving afterwards are dropped.
- States:
  - IDLE: if c0_rd_request, grant 0; else if c1_rd_request, grant 1. On grant, latch address and length (length 0 latched as 1) and go to ISSUE. Same-cycle requests go to client 0.
  - ISSUE: rd_request=1 for exactly one cycle with latched address/length; go to BURST. The request is registered, so it is visible 1 cycle after the grant decision.
  - BURST: each rd_available increments the word counter and is forwarded combinationally to the owner (data unmodified, zero added latency). The other client's available stays 0. When the counter reaches the latched length: pulse cX_rd_done in the cycle following the last word, clear the counter, return to IDLE.
- Back-to-back bursts: minimum 1 IDLE cycle between done and the next rd_request.
- Watchdog: counter clears on every rd_available; it reaches TIMEOUT_CYCLES-1 in BURST -> set timeout_error (sticky until reset), no done pulse, return to IDLE.
- Requests stay asserted by the client until cX_rd_done. A request dropped mid-burst does not cancel the burst; remaining words are still counted and then discarded (available stays 0 for that client).
- rd_available in IDLE/ISSUE: ignored, not counted.
- Counters are BURST_WIDTH bits; the watchdog is clog2(TIMEOUT_CYCLES) bits and saturates.

Optional Feature:
RAM_READ_ARBITER_FAIRNESS_EN
- Defined: a wait counter increments each cycle client 1 requests in IDLE without a grant. When it reaches MAX_WAIT, the next IDLE arbitration grants client 1 even if client 0 requests. The counter clears on a client-1 grant.
- Undefined: strict client-0 priority; MAX_WAIT unused; client 1 may starve.

Decomposition:
- Shared package/include (constant.v style): state encodings ARB_IDLE/ARB_ISSUE/ARB_BURST, client ids, default widths.
- One natural sub-module, burst_watchdog: load/clear on strobe, saturating count, expiry flag. All other logic stays in one module.

Test Plan:
- Single c0 burst, address 0x000100, length 8, ram returns 8 words 1 cycle apart -> one rd_request pulse with addr 0x000100/len 8; c0 gets 8 available strobes; c0_rd_done 1 cycle after the 8th word; c1 sees nothing.
- c0 and c1 request in the same cycle (lengths 4 and 2) -> c0 served first; c1 rd_request issued after c0 done plus 1 IDLE cycle; owner 0 then 1.
- c1 burst length 0 -> ram receives length 1; done after 1 word.
- c1 burst of 16, ram stops after 5 words, TIMEOUT_CYCLES=32 -> timeout_error=1 at 32 idle cycles, state IDLE, no done; c0 request afterwards served normally.
- reset_n low for 3 cycles mid-burst after 3 of 8 words -> outputs 0 immediately; later stray words produce no available strobes.
- FAIRNESS_EN, MAX_WAIT=4, c0 requests continuously with len 1, c1 requesting -> c1 granted no later than after 4 waiting IDLE cycles; without the macro c1 is never granted.
